mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
Memory/peripheral bus access controller directly downstream of the CPU address register. It consumes the latched 32-bit address plus a read or write request from the control unit. It runs one single-beat valid/ready transaction on the data bus and returns aligned, extended read data with a done/error pulse. Misaligned and illegal-size accesses are rejected locally, and no bus transaction is issued for them.

Parameters:
TIMEOUT_CYCLES, 16, number of bus_valid cycles without bus_ready before the access is aborted (used only with the optional feature)
CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
i_addr  in  32  access address (from address register output)
i_wdata  in  32  store data, right-justified
i_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_unsigned  in  1  1 zero-extends loads, 0 sign-extends loads
i_req_rd  in  1  load request, sampled in IDLE only
i_req_wr  in  1  store request, sampled in IDLE only
o_rdata  out  32  extended load result, valid while o_done=1
o_busy  out  1  high whenever state is not IDLE
o_done  out  1  one-cycle completion pulse
o_err  out  1  qualifies o_done: access failed
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  out  32  store data replicated to all lanes
bus_be  out  4  byte enables
bus_we  out  1  1 write, 0 read
bus_valid  out  1  transaction request
bus_ready  in  1  slave accept/complete
bus_rdata  in  32  slave read data, valid with bus_ready

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including bus_valid, bus_be and o_rdata; timeout counter 0. Reset mid-transaction drops bus_valid immediately and produces no o_done.
- States: IDLE, REQ, DONE.
- IDLE, cycle T: if exactly one of i_req_rd/i_req_wr is high, latch addr, wdata, size, unsigned and direction.
  - Legal access: go to REQ.
  - Illegal access: go to DONE with o_err=1. Illegal means size=11, half with addr[0]=1, word with addr[1:0]!=0, or both requests high.
- Byte enables: byte gives 4'b0001<<addr[1:0]; half gives 4'b0011<<{addr[1],1'b0}; word gives 4'b1111.
- Store data: byte is {4{wdata[7:0]}}; half is {2{wdata[15:0]}}; word is wdata.
- REQ (from T+1): bus_valid=1. bus_addr, bus_be, bus_we and bus_wdata are registered and held stable until bus_ready is sampled high. On that edge, capture bus_rdata and go to DONE.
- DONE: o_done=1 for exactly one cycle; o_err as decided; then return to IDLE.
  - o_rdata holds the selected lane, extended per size and i_unsigned.
  - Stores and errors return o_rdata=0.
- Minimum latency from request to o_done is 2 cycles, when bus_ready is high in the first REQ cycle.
- bus_valid is 0 in IDLE and DONE. Back-to-back accesses therefore have a 1-cycle bus gap.
- Requests arriving while o_busy=1 are ignored; there is no queuing. o_busy=1 in REQ and DONE.
- bus_ready while not in REQ is ignored.

Optional Feature:
MEMBUS_TIMEOUT_EN
- Defined: the counter increments each REQ cycle in which bus_ready=0. When it reaches TIMEOUT_CYCLES, bus_valid drops and the block enters DONE with o_err=1 and o_rdata=0. The counter clears on leaving REQ.
- Undefined: no counter logic; REQ waits indefinitely for bus_ready.

Test Plan:
- Word load, addr=0x0000_1004, bus_ready=1 in the first REQ cycle, bus_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x1004, o_done at T+2, o_rdata=0xDEADBEEF, o_err=0.
- Byte load signed, addr=0x0000_2003, bus_rdata=0x80000000 -> bus_be=1000, o_rdata=0xFFFFFF80; the same load with i_unsigned=1 -> o_rdata=0x00000080.
- Half store, addr=0x0000_3002, wdata=0x1234ABCD, bus_ready delayed 3 cycles -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1; bus signals stable for 4 cycles; o_done 1 cycle after ready.
- Misaligned word load, addr=0x0000_0006 -> no bus_valid ever; o_done and o_err high at T+1.
- Timeout with macro defined and TIMEOUT_CYCLES=16, bus_ready held 0 -> bus_valid high exactly 16 cycles, then o_done=1 and o_err=1.
- Async reset asserted 2 cycles into REQ -> bus_valid=0 before the next clk edge; no o_done; a new request after release completes normally.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Single-beat valid/ready bus access controller: aligns, enables and extends CPU loads/stores.
// Optional bus timeout abort is compiled in when MEMBUS_TIMEOUT_EN is defined.
module mem_bus_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic        i_req_rd,
   input  logic        i_req_wr,
   output logic [31:0] o_rdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   output logic        bus_we,
   output logic        bus_valid,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_check
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
   end

   state_t      state_reg, state_next;
   logic [1:0]  size_reg;
   logic [1:0]  lane_reg;
   logic        unsigned_reg;
   logic        err_reg, err_next;
   logic [31:0] rdata_reg, rdata_next;
   logic        load_req;
   logic        illegal;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic        timeout_hit;

   always_comb begin
      illegal = (i_req_rd & i_req_wr);
      be_calc = 4'b0000;
      wdata_calc = i_wdata;
      case (i_size)
         2'b00: begin
            be_calc    = 4'b0001 << i_addr[1:0];
            wdata_calc = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << {i_addr[1], 1'b0};
            wdata_calc = {2{i_wdata[15:0]}};
            illegal    = illegal | i_addr[0];
         end
         2'b10: begin
            be_calc    = 4'b1111;
            illegal    = illegal | (i_addr[1:0] != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
   end

   // Lane extraction uses the offset captured at request time, not the live address.
   always_comb begin
      byte_sel = bus_rdata[{lane_reg, 3'b000} +: 8];
      half_sel = bus_rdata[{lane_reg[1], 4'b0000} +: 16];
      case (size_reg)
         2'b00:   load_ext = unsigned_reg ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = unsigned_reg ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_ext = bus_rdata;
      endcase
   end

`ifdef MEMBUS_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_reg;

   assign timeout_hit = (state_reg == REQ) && !bus_ready &&
                        (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (state_reg == REQ && state_next == REQ) begin
         cnt_reg <= cnt_reg + CNT_W'(!bus_ready);
      end else begin
         cnt_reg <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      err_next   = err_reg;
      rdata_next = rdata_reg;
      load_req   = 1'b0;
      case (state_reg)
         IDLE: begin
            rdata_next = '0;
            if (i_req_rd | i_req_wr) begin
               load_req   = 1'b1;
               err_next   = illegal;
               state_next = illegal ? DONE : REQ;
            end
         end
         REQ: begin
            if (bus_ready) begin
               state_next = DONE;
               err_next   = 1'b0;
               rdata_next = bus_we ? 32'd0 : load_ext;
            end else if (timeout_hit) begin
               state_next = DONE;
               err_next   = 1'b1;
               rdata_next = '0;
            end
         end
         DONE: begin
            state_next = IDLE;
            err_next   = 1'b0;
            rdata_next = '0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         err_reg      <= 1'b0;
         rdata_reg    <= '0;
         size_reg     <= '0;
         lane_reg     <= '0;
         unsigned_reg <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_be       <= '0;
         bus_we       <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= err_next;
         rdata_reg <= rdata_next;
         if (load_req) begin
            size_reg     <= i_size;
            lane_reg     <= i_addr[1:0];
            unsigned_reg <= i_unsigned;
            bus_addr     <= {i_addr[31:2], 2'b00};
            bus_wdata    <= wdata_calc;
            bus_be       <= be_calc;
            bus_we       <= i_req_wr;
         end
      end
   end

   assign bus_valid = (state_reg == REQ);
   assign o_busy    = (state_reg != IDLE);
   assign o_done    = (state_reg == DONE);
   assign o_err     = (state_reg == DONE) & err_reg;
   assign o_rdata   = rdata_reg;

endmodule
